// File: rtl/scsi_pkg.sv
// rtl/scsi_pkg.sv - shared types for the SCSI target link
// Purpose: bus phase encoding {MSG,CD,IO} and target link FSM states.
package scsi_pkg;

    typedef enum logic [2:0] {
        DATA_OUT = 3'b000,
        DATA_IN  = 3'b001,
        CMD      = 3'b010,
        STATUS   = 3'b011,
        MSG_OUT  = 3'b110,
        MSG_IN   = 3'b111
    } phase_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEL_WAIT = 3'd1,
        SEL_HOLD = 3'd2,
        READY    = 3'd3,
        SETTLE   = 3'd4,
        REQ_ON   = 3'd5,
        REQ_OFF  = 3'd6
    } state_t;

endpackage

// File: rtl/scsi_target_link.sv
// rtl/scsi_target_link.sv - SCSI target bus engine (selection, phases, REQ/ACK bytes)
// Purpose: answers selection, owns BSY and the phase lines, runs the target side of
//  the REQ/ACK handshake and exposes a TX/RX byte stream to the drive sequencer.
// Ports:
//  CLK, RESn (async active-low), CE (clock enable)
//  SCSI_DI/SCSI_DO/SCSI_DOE            data bus in/out/drive-enable
//  SCSI_SELn/ATNn/ACKn/RSTn            initiator controls (active-low)
//  SCSI_BSYn/REQn/MSGn/CDn/IOn         target controls (active-low)
//  PH_SEL/PH_GO, REL                   phase request, bus release
//  TX_DATA/TX_VALID/TX_READY           bytes to initiator
//  RX_DATA/RX_VALID                    bytes from initiator
//  SELECTED, ATN, RST_DET              status
module scsi_target_link
    import scsi_pkg::*;
#(
    parameter int TARGET_ID  = 6,
    parameter int SETTLE_CYC = 4,
    parameter int SEL_DLY    = 2
) (
    input  logic       CLK,
    input  logic       RESn,
    input  logic       CE,
    input  logic [7:0] SCSI_DI,
    output logic [7:0] SCSI_DO,
    output logic       SCSI_DOE,
    input  logic       SCSI_SELn,
    input  logic       SCSI_ATNn,
    input  logic       SCSI_ACKn,
    input  logic       SCSI_RSTn,
    output logic       SCSI_BSYn,
    output logic       SCSI_REQn,
    output logic       SCSI_MSGn,
    output logic       SCSI_CDn,
    output logic       SCSI_IOn,
    input  logic [2:0] PH_SEL,
    input  logic       PH_GO,
    input  logic       REL,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       SELECTED,
    output logic       ATN,
    output logic       RST_DET
);

    localparam int MAXC = (SETTLE_CYC > SEL_DLY) ? SETTLE_CYC : SEL_DLY;
    localparam int CW   = $clog2(MAXC + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bsy_n_q, bsy_n_d;
    logic          req_n_q, req_n_d;
    logic [2:0]    ph_q, ph_d;          // {MSG,CD,IO}, active-high
    logic [7:0]    do_q, do_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          sel_q, sel_d;
    logic          rst_det_q, rst_det_d;
    logic          rst_hold_q, rst_hold_d;   // bus reset already reported
    logic          rel_pend_q, rel_pend_d;
    logic          rx_act_q, rx_act_d;       // auto-request bytes in an IO=0 phase
    logic          byte_pend_q, byte_pend_d; // SETTLE leads to REQ, not back to READY
    logic          atn_s1_q, atn_s2_q;

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bsy_n_q     <= 1'b1;
            req_n_q     <= 1'b1;
            ph_q        <= 3'b000;
            do_q        <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            sel_q       <= 1'b0;
            rst_det_q   <= 1'b0;
            rst_hold_q  <= 1'b0;
            rel_pend_q  <= 1'b0;
            rx_act_q    <= 1'b0;
            byte_pend_q <= 1'b0;
            atn_s1_q    <= 1'b0;
            atn_s2_q    <= 1'b0;
        end else if (CE) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bsy_n_q     <= bsy_n_d;
            req_n_q     <= req_n_d;
            ph_q        <= ph_d;
            do_q        <= do_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            sel_q       <= sel_d;
            rst_det_q   <= rst_det_d;
            rst_hold_q  <= rst_hold_d;
            rel_pend_q  <= rel_pend_d;
            rx_act_q    <= rx_act_d;
            byte_pend_q <= byte_pend_d;
            atn_s1_q    <= ~SCSI_ATNn;
            atn_s2_q    <= atn_s1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bsy_n_d     = bsy_n_q;
        req_n_d     = req_n_q;
        ph_d        = ph_q;
        do_d        = do_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        sel_d       = sel_q;
        rst_det_d   = 1'b0;
        rst_hold_d  = 1'b0;
        rel_pend_d  = rel_pend_q;
        rx_act_d    = rx_act_q;
        byte_pend_d = byte_pend_q;

        if (!SCSI_RSTn) begin
            // Bus reset: drop everything, report once per reset assertion.
            state_d     = IDLE;
            cnt_d       = '0;
            bsy_n_d     = 1'b1;
            req_n_d     = 1'b1;
            ph_d        = 3'b000;
            do_d        = 8'h00;
            rx_data_d   = 8'h00;
            sel_d       = 1'b0;
            rst_det_d   = ~rst_hold_q;
            rst_hold_d  = 1'b1;
            rel_pend_d  = 1'b0;
            rx_act_d    = 1'b0;
            byte_pend_d = 1'b0;
        end else begin
            if (REL && state_q != READY && state_q != IDLE) begin
                rel_pend_d = 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (!SCSI_SELn && bsy_n_q && SCSI_DI[TARGET_ID]) begin
                        state_d = SEL_WAIT;
                        cnt_d   = CW'(SEL_DLY - 1);
                    end
                end
                SEL_WAIT: begin
                    if (SCSI_SELn || !SCSI_DI[TARGET_ID]) begin
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        bsy_n_d = 1'b0;
                        state_d = SEL_HOLD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                SEL_HOLD: begin
                    if (SCSI_SELn) begin
                        sel_d   = 1'b1;
                        state_d = READY;
                    end
                end
                READY: begin
                    // Priority: release, then phase change, then data.
                    if (REL || rel_pend_q) begin
                        bsy_n_d     = 1'b1;
                        ph_d        = 3'b000;
                        sel_d       = 1'b0;
                        rel_pend_d  = 1'b0;
                        rx_act_d    = 1'b0;
                        byte_pend_d = 1'b0;
                        state_d     = IDLE;
                    end else if (PH_GO) begin
                        ph_d        = PH_SEL;
                        rx_act_d    = ~PH_SEL[0];
                        byte_pend_d = 1'b0;
                        cnt_d       = CW'(SETTLE_CYC - 1);
                        state_d     = SETTLE;
                    end else if (ph_q[0] && TX_VALID) begin
                        do_d        = TX_DATA;
                        byte_pend_d = 1'b1;
                        cnt_d       = CW'(SETTLE_CYC - 1);
                        state_d     = SETTLE;
                    end else if (!ph_q[0] && rx_act_q) begin
                        byte_pend_d = 1'b1;
                        cnt_d       = CW'(SETTLE_CYC - 1);
                        state_d     = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (byte_pend_q) begin
                        req_n_d = 1'b0;
                        state_d = REQ_ON;
                    end else begin
                        state_d = READY;
                    end
                end
                REQ_ON: begin
                    if (!SCSI_ACKn) begin
                        if (!ph_q[0]) begin
                            rx_data_d  = SCSI_DI;
                            rx_valid_d = 1'b1;
                        end
                        req_n_d     = 1'b1;
                        byte_pend_d = 1'b0;
                        state_d     = REQ_OFF;
                    end
                end
                REQ_OFF: begin
                    if (SCSI_ACKn) begin
                        state_d = READY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign SCSI_DO   = do_q;
    assign SCSI_DOE  = ph_q[0];
    assign SCSI_BSYn = bsy_n_q;
    assign SCSI_REQn = req_n_q;
    assign SCSI_MSGn = ~ph_q[2];
    assign SCSI_CDn  = ~ph_q[1];
    assign SCSI_IOn  = ~ph_q[0];
    assign TX_READY  = (state_q == READY) && ph_q[0] && SCSI_RSTn &&
                       !REL && !rel_pend_q && !PH_GO;
    assign RX_DATA   = rx_data_q;
    assign RX_VALID  = rx_valid_q;
    assign SELECTED  = sel_q;
    assign ATN       = atn_s2_q;
    assign RST_DET   = rst_det_q;

endmodule
